// File: rtl/ir_beam_tx.sv
// rtl/ir_beam_tx.sv - IR beam emitter with burst-gated carrier and receiver-judged beam-break detection
//
// Drives the IR emitter with framed carrier bursts (ON_CYC carrier periods on,
// OFF_CYC periods off) and checks the active-low demodulating receiver against
// them. The frame is judged on its last OFF clock, and the result is debounced
// over several frames into beam_blocked. A clear-to-blocked transition produces
// a one-clock goal_pulse.
//
// Optional feature macro: IR_BEAM_FAULT_EN
//   defined     - a receiver that reports carrier while the emitter is off
//                 raises fault after STUCK_TH frames and freezes the beam state
//   not defined - no stuck detection; fault is tied low
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   transmitter enable (level); low aborts the frame and clears all state
//   ir_rx_n      in   receiver output, asynchronous, low = carrier detected
//   ir_led       out  emitter drive, high = LED on
//   beam_blocked out  debounced beam state
//   goal_pulse   out  one-clock pulse on a clear-to-blocked transition
//   fault        out  receiver-stuck indication
module ir_beam_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int CARRIER_HZ = 38_000,
    parameter int ON_CYC     = 16,
    parameter int OFF_CYC    = 16,
    parameter int MISS_TH    = 3,
    parameter int HIT_TH     = 2,
    parameter int STUCK_TH   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ir_rx_n,
    output logic ir_led,
    output logic beam_blocked,
    output logic goal_pulse,
    output logic fault
);

    localparam int HALF = CLK_HZ / (2 * CARRIER_HZ);
    localparam int PER  = 2 * HALF;
    localparam int PW   = (PER > 1) ? $clog2(PER) : 1;
    localparam int MAXC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int MW   = $clog2(MISS_TH + 1);
    localparam int HW   = $clog2(HIT_TH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    rx_sync;
    logic          rx;
    logic [PW-1:0] ph_cnt;     // clock within the current carrier period
    logic [CW-1:0] per_cnt;    // carrier period within the current ON or OFF phase
    logic          hit_flag;
    logic [MW-1:0] miss_cnt, miss_nxt;
    logic [HW-1:0] hit_cnt, hit_nxt;
    logic          fault_q, fault_nxt;
    logic          period_end, on_last, off_last, hit_now;

    assign rx         = rx_sync[1];
    assign period_end = (ph_cnt == PW'(PER - 1));
    assign on_last    = period_end && (per_cnt == CW'(ON_CYC - 1));
    assign off_last   = period_end && (per_cnt == CW'(OFF_CYC - 1));
    // Only the second half of the burst counts, which tolerates receiver latency.
    assign hit_now    = (state == S_ON) && (per_cnt >= CW'(ON_CYC / 2)) && !rx;

    // Carrier starts high at each period start; the decode is from registers only.
    assign ir_led = (state == S_ON) && (ph_cnt < PW'(HALF));

    always_comb begin
        miss_nxt = '0;
        hit_nxt  = '0;
        if (hit_flag) begin
            hit_nxt = (hit_cnt == HW'(HIT_TH)) ? hit_cnt : hit_cnt + 1'b1;
        end else begin
            miss_nxt = (miss_cnt == MW'(MISS_TH)) ? miss_cnt : miss_cnt + 1'b1;
        end
    end

`ifdef IR_BEAM_FAULT_EN
    localparam int SW = $clog2(STUCK_TH + 1);
    logic [SW-1:0] stuck_cnt, stuck_nxt;
    logic          stuck_flag, stuck_now, frame_stuck;

    // Carrier reported while the emitter has been dark for half the OFF phase.
    assign stuck_now   = (state == S_OFF) && (per_cnt >= CW'(OFF_CYC / 2)) && !rx;
    // The last OFF clock is also a stuck sample, so fold it in directly.
    assign frame_stuck = stuck_flag || stuck_now;

    always_comb begin
        stuck_nxt = '0;
        if (frame_stuck) begin
            stuck_nxt = (stuck_cnt == SW'(STUCK_TH)) ? stuck_cnt : stuck_cnt + 1'b1;
        end
        fault_nxt = frame_stuck && (fault_q || (stuck_nxt == SW'(STUCK_TH)));
    end
`else
    assign fault_q   = 1'b0;
    assign fault_nxt = 1'b0;
`endif

    assign fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync      <= 2'b11;
            state        <= S_IDLE;
            ph_cnt       <= '0;
            per_cnt      <= '0;
            hit_flag     <= 1'b0;
            miss_cnt     <= '0;
            hit_cnt      <= '0;
            beam_blocked <= 1'b0;
            goal_pulse   <= 1'b0;
`ifdef IR_BEAM_FAULT_EN
            stuck_flag   <= 1'b0;
            stuck_cnt    <= '0;
            fault_q      <= 1'b0;
`endif
        end else begin
            rx_sync    <= {rx_sync[0], ir_rx_n};
            goal_pulse <= 1'b0;
            if (!en) begin
                // Abort: the partial frame is dropped and detection restarts from CLEAR.
                state        <= S_IDLE;
                ph_cnt       <= '0;
                per_cnt      <= '0;
                hit_flag     <= 1'b0;
                miss_cnt     <= '0;
                hit_cnt      <= '0;
                beam_blocked <= 1'b0;
`ifdef IR_BEAM_FAULT_EN
                stuck_flag   <= 1'b0;
                stuck_cnt    <= '0;
                fault_q      <= 1'b0;
`endif
            end else begin
                if (period_end) begin
                    ph_cnt <= '0;
                end else begin
                    ph_cnt <= ph_cnt + 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        state   <= S_ON;
                        ph_cnt  <= '0;
                        per_cnt <= '0;
                    end
                    S_ON: begin
                        if (hit_now) begin
                            hit_flag <= 1'b1;
                        end
                        if (on_last) begin
                            state   <= S_OFF;
                            per_cnt <= '0;
                        end else if (period_end) begin
                            per_cnt <= per_cnt + 1'b1;
                        end
                    end
                    S_OFF: begin
`ifdef IR_BEAM_FAULT_EN
                        if (stuck_now) begin
                            stuck_flag <= 1'b1;
                        end
`endif
                        if (off_last) begin
                            state    <= S_ON;
                            per_cnt  <= '0;
                            hit_flag <= 1'b0;
                            miss_cnt <= miss_nxt;
                            hit_cnt  <= hit_nxt;
`ifdef IR_BEAM_FAULT_EN
                            stuck_flag <= 1'b0;
                            stuck_cnt  <= stuck_nxt;
                            fault_q    <= fault_nxt;
`endif
                            // A faulty receiver cannot be trusted, so the beam state freezes.
                            if (!fault_nxt) begin
                                if (!beam_blocked && (miss_nxt >= MW'(MISS_TH))) begin
                                    beam_blocked <= 1'b1;
                                    goal_pulse   <= 1'b1;
                                end else if (beam_blocked && (hit_nxt >= HW'(HIT_TH))) begin
                                    beam_blocked <= 1'b0;
                                end
                            end
                        end else if (period_end) begin
                            per_cnt <= per_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_beam_tx.sv
// tb/tb_ir_beam_tx.sv - self-checking bench for ir_beam_tx with a frame-level reference model
module tb_ir_beam_tx;

    localparam int FRAME = 160;
    localparam int M_LOOP = 0;
    localparam int M_HIGH = 1;
    localparam int M_LOW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic ir_rx_n;
    logic ir_led, beam_blocked, goal_pulse, fault;
    logic [2:0] dly = 3'b000;
    int mode = M_LOOP;

    int n_cmp = 0;
    int n_bad = 0;

    int m_miss, m_hit, m_stuck;
    bit m_blk, m_flt, m_pulse;

    ir_beam_tx #(
        .CLK_HZ(1_000_000), .CARRIER_HZ(50_000), .ON_CYC(4), .OFF_CYC(4),
        .MISS_TH(3), .HIT_TH(2), .STUCK_TH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ir_rx_n(ir_rx_n),
        .ir_led(ir_led), .beam_blocked(beam_blocked),
        .goal_pulse(goal_pulse), .fault(fault)
    );

    always #5 clk = ~clk;

    // Loopback receiver: sees the LED three clocks late, active low.
    always @(posedge clk) dly <= {dly[1:0], ir_led};
    assign ir_rx_n = (mode == M_LOOP) ? ~dly[2] : (mode == M_HIGH);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_miss = 0; m_hit = 0; m_stuck = 0;
        m_blk = 0; m_flt = 0; m_pulse = 0;
    endtask

    // One frame judged from the receiver mode: loopback and stuck-low both look like hits.
    task automatic model_frame(input int md);
        bit hit, stuck;
        hit = (md != M_HIGH);
        stuck = (md == M_LOW);
        m_pulse = 0;
        if (hit) begin
            m_miss = 0;
            m_hit = (m_hit < 2) ? m_hit + 1 : 2;
        end else begin
            m_hit = 0;
            m_miss = (m_miss < 3) ? m_miss + 1 : 3;
        end
`ifdef IR_BEAM_FAULT_EN
        if (stuck) begin
            m_stuck = (m_stuck < 8) ? m_stuck + 1 : 8;
            if (m_stuck >= 8) m_flt = 1;
        end else begin
            m_stuck = 0;
            m_flt = 0;
        end
`else
        if (stuck) m_stuck = 0;
        m_flt = 0;
`endif
        if (!m_flt) begin
            if (!m_blk && m_miss >= 3) begin
                m_blk = 1;
                m_pulse = 1;
            end else if (m_blk && m_hit >= 2) begin
                m_blk = 0;
            end
        end
    endtask

    task automatic start_en();
        en = 1'b1;
        tick();
        model_clear();
    endtask

    // Entered at frame clock 0, leaves at the next frame's clock 0 after checking the verdict.
    task automatic run_frame(input int md, input string tag);
        int led_bad, pulse_cnt, hold_bad;
        bit exp_led;
        led_bad = 0; pulse_cnt = 0; hold_bad = 0;
        mode = md;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick();
            exp_led = ((k % 20) < 10) && (k < 80);
            if (ir_led !== exp_led) led_bad++;
            if (k > 0 && goal_pulse !== 1'b0) pulse_cnt++;
            if (beam_blocked !== m_blk || fault !== m_flt) hold_bad++;
        end
        n_cmp++;
        if (led_bad != 0) begin n_bad++; $display("FAIL %s led_wave: %0d clocks wrong, required 0", tag, led_bad); end
        n_cmp++;
        if (pulse_cnt != 0) begin n_bad++; $display("FAIL %s mid_pulse: %0d pulses, required 0", tag, pulse_cnt); end
        n_cmp++;
        if (hold_bad != 0) begin n_bad++; $display("FAIL %s state_hold: %0d clocks changed, required 0", tag, hold_bad); end
        tick();
        model_frame(md);
        n_cmp++;
        if (beam_blocked !== m_blk) begin n_bad++; $display("FAIL %s beam_blocked: got %b required %b", tag, beam_blocked, m_blk); end
        n_cmp++;
        if (goal_pulse !== m_pulse) begin n_bad++; $display("FAIL %s goal_pulse: got %b required %b", tag, goal_pulse, m_pulse); end
        n_cmp++;
        if (fault !== m_flt) begin n_bad++; $display("FAIL %s fault: got %b required %b", tag, fault, m_flt); end
    endtask

    task automatic check_quiet(input string tag);
        n_cmp++;
        if ({ir_led, beam_blocked, goal_pulse, fault} !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s outputs: got led/blk/pulse/fault=%b required 0000", tag,
                     {ir_led, beam_blocked, goal_pulse, fault});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = M_LOOP;
        repeat (3) tick();
        check_quiet("reset_held");
        rst_n = 1'b1;
        repeat (5) tick();
        check_quiet("idle_disabled");
    endtask

    task automatic test_loopback();
        start_en();
        for (int f = 0; f < 10; f++) run_frame(M_LOOP, "loopback");
    endtask

    task automatic test_block();
        for (int f = 0; f < 3; f++) run_frame(M_HIGH, "block");
        for (int f = 0; f < 3; f++) run_frame(M_LOOP, "unblock");
    endtask

    task automatic test_short_block();
        for (int f = 0; f < 2; f++) run_frame(M_HIGH, "short_block");
        for (int f = 0; f < 2; f++) run_frame(M_LOOP, "short_restore");
    endtask

    task automatic test_fault();
        for (int f = 0; f < 9; f++) run_frame(M_LOW, "stuck");
        run_frame(M_LOOP, "stuck_clear");
        run_frame(M_LOOP, "stuck_after");
    endtask

    task automatic test_en_drop();
        int led_on;
        for (int f = 0; f < 3; f++) run_frame(M_HIGH, "pre_drop");
        mode = M_HIGH;
        for (int k = 1; k <= 50; k++) tick();
        en = 1'b0;
        tick();
        check_quiet("en_drop");
        led_on = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ir_led !== 1'b0 || goal_pulse !== 1'b0) led_on++;
        end
        n_cmp++;
        if (led_on != 0) begin n_bad++; $display("FAIL en_off_quiet: %0d active clocks, required 0", led_on); end
        start_en();
        run_frame(M_HIGH, "reenable_miss");
        run_frame(M_LOOP, "reenable_loop");
    endtask

    task automatic test_async_reset();
        for (int f = 0; f < 3; f++) run_frame(M_HIGH, "pre_reset");
        mode = M_LOOP;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        rst_n = 1'b1;
        tick();
        model_clear();
        run_frame(M_LOOP, "post_reset");
        for (int f = 0; f < 3; f++) run_frame(M_HIGH, "post_reset_block");
    endtask

    task automatic test_random();
        int md;
        for (int f = 0; f < 40; f++) begin
            md = $urandom_range(0, 9);
            md = (md < 4) ? M_LOOP : (md < 8) ? M_HIGH : M_LOW;
            run_frame(md, "random");
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_loopback();
        test_block();
        test_short_block();
`ifdef IR_BEAM_FAULT_EN
        test_fault();
`endif
        test_en_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
